// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter and its matching receiver.
// SERIAL_TX_PARITY_EN adds the PARITY state to the frame state machine.
package serial_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clear holds the count at zero so a new frame starts on a clean bit boundary.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit, 8 data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output state_e     dbg_state
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_e                 state_q;
    logic [2:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   tx_q;
    logic                   tick;
    logic                   baud_clear;
`ifdef SERIAL_TX_PARITY_EN
    logic                   parity_q;
`endif

    // Counter idles at zero so the first start-bit cycle is count 0.
    assign baud_clear = (state_q == IDLE);

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= STOP_BIT;
`ifdef SERIAL_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= STOP_BIT;
                    if (tx_valid) begin
                        state_q   <= START;
                        shift_q   <= tx_data;
                        bit_cnt_q <= '0;
                        tx_q      <= START_BIT;
`ifdef SERIAL_TX_PARITY_EN
                        parity_q  <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            state_q   <= PARITY;
                            tx_q      <= parity_q;
`else
                            state_q   <= STOP;
                            tx_q      <= STOP_BIT;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        tx_q    <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state_q <= IDLE;
                        tx_q    <= STOP_BIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= STOP_BIT;
                end
            endcase
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tx_done   = (state_q == STOP) && tick;
    assign tx        = tx_q;
    assign dbg_state = state_q;

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
REQ-002 Port clk  input  1  sole clock; all logic on the rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port tx_data  input  8  byte to send, sampled only on accept.
REQ-005 Port tx_valid  input  1  producer has a byte on tx_data.
REQ-006 Port tx_ready  output  1  block can accept a byte this cycle.
REQ-007 Port tx  output  1  serial line; idles high; registered output.
REQ-008 Port busy  output  1  a frame is in progress, i.e. state is not IDLE.
REQ-009 Port tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-010 Frame format SHALL be: start bit 0, 8 data bits LSB first, optional parity bit (REQ-022), then stop bit 1.
REQ-011 Each bit SHALL hold tx constant for exactly CLKS_PER_BIT cycles.
REQ-012 State machine states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-013 IDLE: tx=1, tx_ready=1, busy=0.
REQ-014 Transitions: IDLE to START on tx_valid&&tx_ready; START to DATA after CLKS_PER_BIT cycles; DATA to PARITY (macro defined) or STOP after bit 7 completes; PARITY to STOP; STOP to IDLE after CLKS_PER_BIT cycles.
REQ-015 Accept: the byte SHALL be latched into an internal shift register on the edge where tx_valid&&tx_ready; tx SHALL be 0 from that edge onward (zero-cycle latency to start bit).
REQ-016 tx_ready SHALL be 0 in every state except IDLE; tx_valid outside IDLE SHALL be ignored and tx_data changes SHALL NOT affect the frame in flight.
REQ-017 Back-to-back: with tx_valid held high, the next byte SHALL be accepted in the first IDLE cycle, giving exactly one idle-high cycle between stop bit and next start bit.
REQ-018 Bit counter SHALL be 3 bits and count 0..7; bit-period counter SHALL be 8 bits, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
REQ-020 tx_done SHALL pulse in the final STOP cycle, coincident with the transition to IDLE.

Reset
REQ-021 While rst=1 at a clock edge: state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, all counters 0. A reset mid-frame SHALL abort the frame, with tx high on the next cycle and no tx_done; rst has priority over a simultaneous tx_valid.

Configuration
REQ-022 Macro SERIAL_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be inserted between bit 7 and the stop bit. Macro undefined: the PARITY state and parity logic SHALL be absent and the frame is 10 bits.

Structure
REQ-023 Package serial_pkg SHALL hold the state enum typedef, the DATA_BITS=8 constant, and the START_BIT=0 and STOP_BIT=1 constants, shared with the receiver.
REQ-024 The bit-period counter SHALL be a sub-module, baud_tick, with inputs clk, rst and clear and a one-cycle output tick every CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4)
REQ-025 Send 8'hA5, no parity -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); tx_done pulses at cycle 40; busy high for cycles 1..40.
REQ-026 SERIAL_TX_PARITY_EN defined, send 8'hA5 -> parity bit 0 and 44-cycle frame; send 8'h07 -> parity bit 1.
REQ-027 tx_valid held high with bytes 8'h55 then 8'h0F -> exactly one idle-high cycle between the frames; tx_ready is high only in that cycle.
REQ-028 Assert rst for 1 cycle during data bit 3 of 8'hFF -> tx=1, tx_ready=1 and busy=0 the next cycle; no tx_done; a new byte 8'h00 then transmits correctly.
REQ-029 Change tx_data from 8'h3C to 8'hC3 mid-frame while tx_valid=1 -> the transmitted bits still equal 8'h3C, and the new value is accepted only in IDLE.
REQ-030 CLKS_PER_BIT=1, send 8'h80 -> 10-cycle frame 0,0,0,0,0,0,0,0,1,1.
